// File: rtl/ysyx_23060077_riscv_ifu.sv
// Multicycle instruction fetch unit: one outstanding imem request, valid/ready hand-off to decode,
// and PC redirects from execute that squash any fetch already in flight.
module ysyx_23060077_riscv_ifu #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    kill_q, kill_d;
    logic [INST_WIDTH-1:0]   inst_d;
    logic [ADDR_WIDTH-1:0]   inst_pc_d;
    logic [ADDR_WIDTH-1:0]   redirect_tgt;
    logic [ADDR_WIDTH-1:0]   pc_inc;

    assign redirect_tgt  = redirect_pc & ~ADDR_WIDTH'(3);
    assign pc_inc        = pc_q + ADDR_WIDTH'(4);
    assign imem_req_addr = req_addr_q;

    // Next-state and datapath; a redirect overrides every other event in its cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        kill_d     = kill_q;
        inst_d     = inst;
        inst_pc_d  = inst_pc;

        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                req_addr_d = redirect_valid ? redirect_tgt : pc_q;
            end
            S_REQ: begin
                // The request already on the bus finishes with its old address; its data is squashed.
                if (redirect_valid) begin
                    kill_d = 1'b1;
                end
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d     = 1'b0;
                        req_addr_d = redirect_valid ? redirect_tgt : pc_q;
                        state_d    = S_REQ;
                    end else begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = req_addr_q;
                        state_d   = S_OUT;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    req_addr_d = redirect_tgt;
                    state_d    = S_REQ;
                end else if (inst_ready) begin
                    pc_d       = pc_inc;
                    req_addr_d = pc_inc;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered decodes of the next state so decode never sees a glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            req_addr_q     <= '0;
            kill_q         <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_addr_q     <= req_addr_d;
            kill_q         <= kill_d;
            inst           <= inst_d;
            inst_pc        <= inst_pc_d;
            imem_req_valid <= (state_d == S_REQ);
            inst_valid     <= (state_d == S_OUT);
        end
    end

endmodule
